// File: rtl/pwm_pkg.sv
// Shared defaults and duty-step arithmetic for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned DEF_WIDTH    = 5;
    localparam int unsigned DEF_CHANNELS = 2;
    localparam int unsigned DEF_PRESCALE = 11;
    localparam int unsigned DEF_DEB_BITS = 16;
    localparam int unsigned DUTY_MAX_W   = 16;

    typedef logic [DUTY_MAX_W-1:0] duty_word_t;

    // One duty step; callers truncate to their width, which yields modulo wrap when sat=0.
    function automatic duty_word_t sat_step(input duty_word_t duty, input logic up,
                                            input logic sat, input duty_word_t max_val);
        duty_word_t res;
        if (up) begin
            res = (sat && (duty == max_val)) ? duty : duty + duty_word_t'(1);
        end else begin
            res = (sat && (duty == '0)) ? duty : duty - duty_word_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced level with
// single-cycle rise/fall pulses.
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int unsigned DEB_BITS = DEF_DEB_BITS
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]          sync_q, sync_d;
    logic [DEB_BITS-1:0] stab_q, stab_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;

    // Counter runs only while the synced input disagrees with the accepted level.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        stab_d  = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (&stab_q) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
                fall_d  = ~sync_q[1];
            end else begin
                stab_d = stab_q + DEB_BITS'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= '0;
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: debounced buttons step per-channel duty and start/stop the
// generator; duty changes are shadowed and applied only at period boundaries.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned DEB_BITS = DEF_DEB_BITS,
    parameter int unsigned SATURATE = 1,
    localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      inc,
    input  logic                      dec,
    input  logic                      run_toggle,
    input  logic [SEL_W-1:0]          ch_sel,
    output logic [CHANNELS*WIDTH-1:0] duty_shadow,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_start,
    output logic                      running
);

    localparam int unsigned DUTY_MAX = (32'd1 << WIDTH) - 32'd1;

    logic inc_lvl, inc_rise, inc_fall;
    logic dec_lvl, dec_rise, dec_fall;
    logic tgl_lvl, tgl_rise, tgl_fall;
    logic btn_unused;

    btn_debounce #(.DEB_BITS(DEB_BITS)) u_inc (
        .CLK(CLK), .RST(RST), .btn_raw(inc), .level(inc_lvl), .rise(inc_rise), .fall(inc_fall)
    );
    btn_debounce #(.DEB_BITS(DEB_BITS)) u_dec (
        .CLK(CLK), .RST(RST), .btn_raw(dec), .level(dec_lvl), .rise(dec_rise), .fall(dec_fall)
    );
    btn_debounce #(.DEB_BITS(DEB_BITS)) u_tgl (
        .CLK(CLK), .RST(RST), .btn_raw(run_toggle), .level(tgl_lvl), .rise(tgl_rise),
        .fall(tgl_fall)
    );

    assign btn_unused = ^{inc_lvl, inc_fall, dec_lvl, dec_fall, tgl_lvl, tgl_rise};

    logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0] active_q, active_d;
    logic [PRESCALE-1:0]            presc_q, presc_d;
    logic [WIDTH-1:0]               cnt_q, cnt_d;
    logic                           running_q, running_d;
    logic                           pstart_q, pstart_d;
    logic [CHANNELS-1:0]            pwm_q, pwm_d;
    logic                           tick, boundary;

    // A stop arriving in a tick cycle suppresses that tick, so a boundary stop never transfers.
    always_comb begin
        running_d = running_q ^ tgl_fall;
        tick      = running_q & running_d & (&presc_q);
        boundary  = tick & (&cnt_q);
        presc_d   = '0;
        cnt_d     = '0;
        if (running_q && running_d) begin
            presc_d = presc_q + PRESCALE'(1);
            cnt_d   = tick ? cnt_q + WIDTH'(1) : cnt_q;
        end
        active_d = boundary ? shadow_q : active_q;
        pstart_d = boundary;
        shadow_d = shadow_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if ((inc_rise ^ dec_rise) && (32'(ch_sel) == i)) begin
                shadow_d[i] = WIDTH'(sat_step(DUTY_MAX_W'(shadow_q[i]), inc_rise,
                                              SATURATE != 0, DUTY_MAX_W'(DUTY_MAX)));
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
        assign pwm_d[g] = running_q & (cnt_q < active_q[g]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q  <= '0;
            active_q  <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            running_q <= 1'b1;
            pstart_q  <= 1'b0;
            pwm_q     <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            pstart_q  <= pstart_d;
            pwm_q     <= pwm_d;
        end
    end

    assign duty_shadow  = shadow_q;
    assign pwm          = pwm_q;
    assign period_start = pstart_q;
    assign running      = running_q;

endmodule
